// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared types and constants for the ram_loader byte-stream memory filler.
//   state_t         : loader FSM state encoding
//   FRAME_HDR_BYTES : header length (ADDR_LO, ADDR_HI, LEN_LO, LEN_HI)
//   CHK_W           : width of the additive payload checksum
//   accepts_byte()  : which states present in_ready to the stream source
// ---------------------------------------------------------------------------
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_LO,
        ADDR_HI,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        CHECK
    } state_t;

    localparam int FRAME_HDR_BYTES = 4;
    localparam int CHK_W           = 8;

    // Every state that consumes a stream byte; IDLE waits for start and
    // WRITE spends its single cycle on the memory strobe.
    function automatic logic accepts_byte(input state_t s);
        return (s != IDLE) && (s != WRITE);
    endfunction

endpackage

// File: rtl/ram_loader.sv
// ---------------------------------------------------------------------------
// ram_loader
// Fills a synchronous RAM from a framed byte stream received over a
// valid/ready handshake. Frame: ADDR_LO ADDR_HI LEN_LO LEN_HI, LEN payload
// bytes, then CHK = (sum of payload) mod 256.
//
// Ports:
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   start             : one-cycle pulse arming the loader (ignored if busy)
//   in_data/in_valid  : stream byte and its valid flag
//   in_ready          : registered; high in states that take a byte
//   mem_cs/mem_we     : one-cycle write strobe pair
//   mem_addr/mem_data : write address / data, held while mem_we is low
//   busy              : frame in progress
//   done/err          : good / bad checksum, sticky until the next start
// ---------------------------------------------------------------------------
module ram_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    state_t           state;
    state_t           next_state;
    logic [15:0]      addr;
    logic [15:0]      len;
    logic [15:0]      count;
    logic [CHK_W-1:0] sum;
    logic             ready_next;
    logic             accept;

    assign accept = in_valid && in_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. The zero-length test after LEN_HI has to look at the
    // incoming high byte because len is only updated on the same edge.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start)  next_state = ADDR_LO;
            ADDR_LO: if (accept) next_state = ADDR_HI;
            ADDR_HI: if (accept) next_state = LEN_LO;
            LEN_LO:  if (accept) next_state = LEN_HI;
            LEN_HI: begin
                if (accept) begin
                    next_state = ({in_data, len[7:0]} == 16'h0000) ? CHECK : DATA;
                end
            end
            DATA:    if (accept) next_state = WRITE;
            WRITE:   next_state = (count == len) ? CHECK : DATA;
            CHECK:   if (accept) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // in_ready is registered from the upcoming state so that, once the
    // register has loaded, it always matches the current state.
    always_comb begin
        ready_next = accepts_byte(next_state);
    end

    // Datapath and registered outputs. The write strobe is launched by the
    // DATA-state accept so it is high exactly during the WRITE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready <= 1'b0;
            mem_cs   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            addr     <= '0;
            len      <= '0;
            count    <= '0;
            sum      <= '0;
        end else begin
            in_ready <= ready_next;
            mem_cs   <= 1'b0;
            mem_we   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        done  <= 1'b0;
                        err   <= 1'b0;
                        sum   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                    end
                end
                ADDR_LO: if (accept) addr[7:0]  <= in_data;
                ADDR_HI: if (accept) addr[15:8] <= in_data;
                LEN_LO:  if (accept) len[7:0]   <= in_data;
                LEN_HI:  if (accept) len[15:8]  <= in_data;
                DATA: begin
                    if (accept) begin
                        mem_data <= DATA_WIDTH'(in_data);
                        mem_addr <= addr[ADDR_WIDTH-1:0];
                        mem_we   <= 1'b1;
                        mem_cs   <= 1'b1;
                        sum      <= sum + in_data;
                        addr     <= addr + 16'd1;
                        count    <= count + 16'd1;
                    end
                end
                CHECK: begin
                    if (accept) begin
                        if (in_data == sum) begin
                            done <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                        busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// ---------------------------------------------------------------------------
// tb_ram_loader
// Table-driven bench for ram_loader: each record is one frame with its
// hand-computed checksum and expected done/err. Written addresses and data
// are predicted from the header and payload. Hand-written sequences cover
// the reset state, random valid gaps and a reset in the middle of DATA.
// ---------------------------------------------------------------------------
module tb_ram_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_cs;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Write log filled by the monitor; the bench only reads it.
    logic [15:0] log_addr [256];
    logic [7:0]  log_data [256];
    int          log_n = 0;
    int          cs_bad = 0;
    int          dbl_we = 0;
    logic        prev_we = 1'b0;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] len;
        logic [31:0] pay;
        logic [7:0]  chk;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    vec_t vecs [6];

    ram_loader #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_cs   (mem_cs),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Memory model: capture every strobed write mid-cycle, and note any
    // cs/we disagreement or a strobe lasting more than one cycle.
    always @(negedge clk) begin
        if (mem_cs != mem_we) cs_bad = cs_bad + 1;
        if (mem_we && prev_we) dbl_we = dbl_we + 1;
        prev_we = mem_we;
        if (mem_we && log_n < 256) begin
            log_addr[log_n] = mem_addr;
            log_data[log_n] = mem_data;
            log_n = log_n + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one byte after an optional idle gap and hold it until the
    // loader takes it; returns just after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit taken;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        taken = 1'b0;
        for (int t = 0; t < 50 && !taken; t++) begin
            if (in_ready) begin
                @(posedge clk);
                taken = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!taken) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("[TB] FAIL accept_timeout: byte %0h not taken, in_ready=%0b expected 1", b, in_ready);
        end
    endtask

    // Run one frame record and compare writes and status with predictions.
    task automatic applyStimulus(input vec_t v, input bit gaps);
        int base;
        base = log_n;
        pulse_start();
        checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
        checkOutput("done_cleared", {31'd0, done}, 32'd0);
        send_byte(v.addr[7:0],  gaps ? int'($urandom_range(0, 3)) : 0);
        send_byte(v.addr[15:8], gaps ? int'($urandom_range(0, 3)) : 0);
        send_byte(v.len[7:0],   gaps ? int'($urandom_range(0, 3)) : 0);
        send_byte(v.len[15:8],  gaps ? int'($urandom_range(0, 3)) : 0);
        for (int i = 0; i < int'(v.len); i++) begin
            send_byte(v.pay[8*i +: 8], gaps ? int'($urandom_range(0, 3)) : 0);
        end
        send_byte(v.chk, gaps ? int'($urandom_range(0, 3)) : 0);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("done", {31'd0, done}, {31'd0, v.exp_done});
        checkOutput("err",  {31'd0, err},  {31'd0, v.exp_err});
        checkOutput("busy_end", {31'd0, busy}, 32'd0);
        checkOutput("in_ready_idle", {31'd0, in_ready}, 32'd0);
        checkOutput("write_count", 32'(log_n - base), {16'd0, v.len});
        for (int i = 0; i < int'(v.len); i++) begin
            if (base + i < 256) begin
                checkOutput("write_addr", {16'd0, log_addr[base+i]}, {16'd0, 16'(v.addr + 16'(i))});
                checkOutput("write_data", {24'd0, log_data[base+i]}, {24'd0, v.pay[8*i +: 8]});
            end
        end
        checkOutput("cs_matches_we", cs_bad, 0);
        checkOutput("we_single_cycle", dbl_we, 0);
    endtask

    initial begin
        int base;
        // AA+BB+CC = 0x231 -> 0x31; FF+01 = 0x100 -> 0x00.
        vecs[0] = '{16'h1000, 16'd3, 32'h00CCBBAA, 8'h31, 1'b1, 1'b0};
        vecs[1] = '{16'h1000, 16'd3, 32'h00CCBBAA, 8'h32, 1'b0, 1'b1};
        vecs[2] = '{16'h1234, 16'd0, 32'h00000000, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{16'hFFFE, 16'd3, 32'h00030201, 8'h06, 1'b1, 1'b0};
        vecs[4] = '{16'h0020, 16'd1, 32'h0000007F, 8'h00, 1'b0, 1'b1};
        vecs[5] = '{16'h0040, 16'd2, 32'h000001FF, 8'h00, 1'b1, 1'b0};

        // Reset state, with a stray valid byte that must not be consumed.
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst_mem_cs",   {31'd0, mem_cs},   32'd0);
        checkOutput("rst_mem_we",   {31'd0, mem_we},   32'd0);
        checkOutput("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        checkOutput("rst_mem_data", {24'd0, mem_data}, 32'd0);
        checkOutput("rst_busy",     {31'd0, busy},     32'd0);
        checkOutput("rst_done",     {31'd0, done},     32'd0);
        checkOutput("rst_err",      {31'd0, err},      32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("idle_no_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("idle_no_write", log_n, 0);
        in_valid = 1'b0;

        for (int k = 0; k < 6; k++) begin
            applyStimulus(vecs[k], 1'b0);
        end

        // Random valid gaps, and valid held high across WRITE cycles.
        // 11+22+33+44 = 0xAA.
        applyStimulus('{16'h0200, 16'd4, 32'h44332211, 8'hAA, 1'b1, 1'b0}, 1'b1);
        applyStimulus('{16'h0300, 16'd4, 32'h04030201, 8'h0A, 1'b1, 1'b0}, 1'b1);

        // Reset after two of five payload bytes.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h05, 0);
        send_byte(8'h05, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        #1;
        rst = 1'b1;
        base = log_n;
        #1;
        checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("midrst_mem_we",   {31'd0, mem_we},   32'd0);
        checkOutput("midrst_mem_cs",   {31'd0, mem_cs},   32'd0);
        checkOutput("midrst_mem_addr", {16'd0, mem_addr}, 32'd0);
        checkOutput("midrst_mem_data", {24'd0, mem_data}, 32'd0);
        checkOutput("midrst_busy",     {31'd0, busy},     32'd0);
        checkOutput("midrst_done",     {31'd0, done},     32'd0);
        checkOutput("midrst_err",      {31'd0, err},      32'd0);
        in_data  = 8'h03;
        in_valid = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("midrst_no_writes", log_n - base, 0);
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("postrst_no_writes", log_n - base, 0);
        applyStimulus(vecs[0], 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time %0t exceeded limit 200000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
